l0_load_scheduler: RTL and testbench
====================================

Name: l0_load_scheduler

Overview:
Sequences SRAM-to-L0 loading for one 3x3 convolution layer. For each kernel position kij it fetches `row` weight words, then `len_onij` activation words, and pushes them into the shared L0 buffer in the order the array-side sequencer consumes them. Activation addresses are generated with the sliding-window mapping from output pixel to input pixel. The block sits between the weight/activation SRAMs and L0, upstream of the L0-to-array sequencer. Only control is generated here; the L0 write data mux is external and is steered by l0_sel_o.

Parameters:
row, 8, weight words per kij (array rows / IC)
len_onij, 16, activation words per kij; must equal out_w*out_w
in_w, 6, input feature-map width
out_w, 4, output feature-map width; in_w = out_w + ksize - 1
ksize, 3, kernel width; kij range 0..ksize*ksize-1
addr_width, 11, SRAM address width
kij_width, 4, width of kij_o

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
start_i  in  1  single-cycle pulse that starts a layer; honoured only in IDLE
next_kij_i  in  1  pulse from the array sequencer: the current kij has been fully consumed
l0_full_i  in  1  L0 back-pressure; asserted while fewer than 2 entries are free
wsram_rd_en_o  out  1  weight SRAM read enable
wsram_addr_o  out  addr_width  weight SRAM address
xsram_rd_en_o  out  1  activation SRAM read enable
xsram_addr_o  out  addr_width  activation SRAM address
l0_wr_en_o  out  1  L0 write strobe, aligned with SRAM read data
l0_sel_o  out  1  L0 data source: 0 = weight SRAM, 1 = activation SRAM
kij_o  out  kij_width  current kernel index
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when the layer completes

Behaviour:
- States: IDLE, LOAD_W, LOAD_X, WAIT, DONE.
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All counters, kij, ki, kj and the pending flag clear to 0.
  - All outputs are 0.
  - An in-flight L0 write is dropped: l0_wr_en_o is 0 on the next cycle.
- SRAM read latency is 1 cycle.
  - l0_wr_en_o and l0_sel_o are the registered copies of (wsram_rd_en_o | xsram_rd_en_o) and xsram_rd_en_o.
- Read enables and addresses are combinational from state, counters and l0_full_i.
  - Any cycle with l0_full_i=1 issues no read, and the counters hold.
- IDLE:
  - start_i=1 -> LOAD_W with kij=0, ki=0, kj=0.
  - start_i in any other state is ignored.
- LOAD_W:
  - Each non-full cycle: wsram_rd_en_o=1, wsram_addr_o = kij*row + wcnt, then wcnt++.
  - After the row-th issue -> LOAD_X, with wcnt cleared.
- LOAD_X:
  - Each non-full cycle: xsram_rd_en_o=1, xsram_addr_o = (oy+ki)*in_w + (ox+kj).
  - ox increments and wraps from out_w-1 to 0; on that wrap, oy increments.
  - No divider is used: ox, oy, ki and kj are separate counters.
  - After the len_onij-th issue -> WAIT, with ox and oy cleared.
- WAIT:
  - On next_kij_i=1, or if the pending flag is set:
    - If kij = ksize*ksize-1 -> DONE.
    - Otherwise kij++ and kj++; when kj wraps from ksize-1 to 0, ki++. Then -> LOAD_W.
  - The pending flag clears on consumption.
- next_kij_i arriving in LOAD_W or LOAD_X sets the pending flag, so WAIT lasts exactly 1 cycle.
  - next_kij_i in IDLE or DONE is ignored.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- Each kij produces exactly row+len_onij L0 writes; a layer produces ksize*ksize*(row+len_onij).
- Address arithmetic is evaluated at addr_width bits and never wraps for legal parameters.

Optional Feature:
L0_LOAD_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o (16 bits, saturating).
  - It counts cycles in LOAD_W or LOAD_X with l0_full_i=1.
  - It clears on reset and on start_i accepted in IDLE.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
1. start_i at cycle 0, l0_full_i=0, next_kij_i never pulsed:
   - wsram_addr_o = 0..7 on cycles 1..8.
   - xsram_addr_o = 0,1,2,3,6,7,8,9,12,13,14,15,18,19,20,21 on cycles 9..24.
   - l0_wr_en_o is high on cycles 2..25, with l0_sel_o=0 on cycles 2..9 and 1 on cycles 10..25.
   - The block then sits in WAIT.
2. Advance to kij=4 (ki=1, kj=1):
   - wsram_addr_o = 32..39.
   - xsram_addr_o runs 7,8,9,10,13 ... ending at 28.
   - kij_o=4.
3. l0_full_i high for 3 cycles after the 3rd weight read:
   - No read enables during those cycles.
   - wsram_addr_o holds at 3.
   - Reads resume at 3, with exactly 8 weight writes in total and no duplicate or skipped address.
4. next_kij_i pulsed during LOAD_X:
   - After the 16th activation read, the block spends 1 cycle in WAIT.
   - It then enters LOAD_W with kij_o incremented, without a second pulse.
5. Full layer with prompt next_kij_i:
   - After kij=8 is consumed, done_o is high for 1 cycle and busy_o then falls.
   - Total L0 writes = 216.
6. reset driven low mid-LOAD_X:
   - Next cycle all outputs are 0 and the state is IDLE.
   - A subsequent start_i restarts at kij=0 with weight address 0.

Source files
------------

// File: rtl/l0_load_scheduler.sv
// SRAM-to-L0 load sequencer for one 3x3 conv layer; optional stall counter via L0_LOAD_STALL_CNT_EN.
// Latency: read enables/addresses combinational; L0 write strobe one cycle after the SRAM read.
// Backpressure: l0_full_i suppresses reads and freezes all counters for that cycle.
module l0_load_scheduler #(
  parameter int row        = 8,
  parameter int len_onij   = 16,
  parameter int in_w       = 6,
  parameter int out_w      = 4,
  parameter int ksize      = 3,
  parameter int addr_width = 11,
  parameter int kij_width  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  next_kij_i,
  input  logic                  l0_full_i,
  output logic                  wsram_rd_en_o,
  output logic [addr_width-1:0] wsram_addr_o,
  output logic                  xsram_rd_en_o,
  output logic [addr_width-1:0] xsram_addr_o,
  output logic                  l0_wr_en_o,
  output logic                  l0_sel_o,
  output logic [kij_width-1:0]  kij_o,
  output logic                  busy_o,
`ifdef L0_LOAD_STALL_CNT_EN
  output logic [15:0]           stall_cnt_o,
`endif
  output logic                  done_o
);

  localparam int cnt_w = $clog2(row > len_onij ? row : len_onij) + 1;
  localparam int pos_w = $clog2(ksize > out_w ? ksize : out_w) + 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [cnt_w-1:0]     wcnt_q, wcnt_d, xcnt_q, xcnt_d;
  logic [pos_w-1:0]     ox_q, ox_d, oy_q, oy_d, ki_q, ki_d, kj_q, kj_d;
  logic [kij_width-1:0] kij_q, kij_d;
  logic                 pend_q, pend_d;
  logic                 w_rd, x_rd;
  logic                 wr_q, sel_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    xcnt_d  = xcnt_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    kij_d   = kij_q;
    pend_d  = pend_q;
    w_rd    = 1'b0;
    x_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD_W;
          kij_d   = '0;
          ki_d    = '0;
          kj_d    = '0;
          wcnt_d  = '0;
          xcnt_d  = '0;
          ox_d    = '0;
          oy_d    = '0;
          pend_d  = 1'b0;
        end
      end
      LOAD_W: begin
        if (next_kij_i) pend_d = 1'b1;
        if (!l0_full_i) begin
          w_rd = 1'b1;
          if (wcnt_q == cnt_w'(row - 1)) begin
            wcnt_d  = '0;
            state_d = LOAD_X;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (next_kij_i) pend_d = 1'b1;
        if (!l0_full_i) begin
          x_rd = 1'b1;
          // Output-pixel scan kept as separate x/y counters to avoid a divider.
          if (ox_q == pos_w'(out_w - 1)) begin
            ox_d = '0;
            oy_d = oy_q + 1'b1;
          end else begin
            ox_d = ox_q + 1'b1;
          end
          if (xcnt_q == cnt_w'(len_onij - 1)) begin
            xcnt_d  = '0;
            ox_d    = '0;
            oy_d    = '0;
            state_d = WAIT;
          end else begin
            xcnt_d = xcnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (next_kij_i || pend_q) begin
          pend_d = 1'b0;
          if (kij_q == kij_width'(ksize * ksize - 1)) begin
            state_d = DONE;
          end else begin
            kij_d   = kij_q + 1'b1;
            state_d = LOAD_W;
            if (kj_q == pos_w'(ksize - 1)) begin
              kj_d = '0;
              ki_d = ki_q + 1'b1;
            end else begin
              kj_d = kj_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      xcnt_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ki_q    <= '0;
      kj_q    <= '0;
      kij_q   <= '0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      xcnt_q  <= xcnt_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ki_q    <= ki_d;
      kj_q    <= kj_d;
      kij_q   <= kij_d;
      pend_q  <= pend_d;
      wr_q    <= w_rd | x_rd;
      sel_q   <= x_rd;
    end
  end

`ifdef L0_LOAD_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      stall_q <= '0;
    end else if ((state_q == LOAD_W || state_q == LOAD_X) && l0_full_i && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
  assign stall_cnt_o = stall_q;
`endif

  assign wsram_rd_en_o = w_rd;
  assign xsram_rd_en_o = x_rd;
  assign wsram_addr_o  = addr_width'(kij_q) * addr_width'(row) + addr_width'(wcnt_q);
  assign xsram_addr_o  = (addr_width'(oy_q) + addr_width'(ki_q)) * addr_width'(in_w)
                       + addr_width'(ox_q) + addr_width'(kj_q);
  assign l0_wr_en_o    = wr_q;
  assign l0_sel_o      = sel_q;
  assign kij_o         = kij_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_l0_load_scheduler.sv
// Bench for l0_load_scheduler: read-stream scoreboard built from the layer mapping plus directed checks.
module tb_l0_load_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        next_kij_i = 1'b0;
  logic        l0_full_i = 1'b0;
  logic        wsram_rd_en_o, xsram_rd_en_o, l0_wr_en_o, l0_sel_o, busy_o, done_o;
  logic [10:0] wsram_addr_o, xsram_addr_o;
  logic [3:0]  kij_o;
`ifdef L0_LOAD_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  l0_load_scheduler dut (
    .clk(clk), .reset(reset), .start_i(start_i), .next_kij_i(next_kij_i), .l0_full_i(l0_full_i),
    .wsram_rd_en_o(wsram_rd_en_o), .wsram_addr_o(wsram_addr_o),
    .xsram_rd_en_o(xsram_rd_en_o), .xsram_addr_o(xsram_addr_o),
    .l0_wr_en_o(l0_wr_en_o), .l0_sel_o(l0_sel_o), .kij_o(kij_o), .busy_o(busy_o),
`ifdef L0_LOAD_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_x; logic [10:0] addr; logic [3:0] kij; } rd_t;
  typedef struct { int rel; bit is_x; logic [10:0] addr; logic [3:0] kij; } rd_log_t;
  typedef struct { int rel; bit sel; } wr_log_t;

  rd_t     exp_q[$];
  bit      sel_q[$];
  rd_log_t rd_log[$];
  wr_log_t wr_log[$];
  int      done_log[$];

  int cyc = 0;
  int start_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - start_cyc);
    end
  endtask

  // Expected layer: per kij, row weight words then the sliding-window activation words.
  task automatic model_init();
    exp_q.delete(); sel_q.delete(); rd_log.delete(); wr_log.delete(); done_log.delete();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back('{1'b0, 11'(k * 8 + i), 4'(k)});
        sel_q.push_back(1'b0);
      end
      for (int p = 0; p < 16; p++) begin
        exp_q.push_back('{1'b1, 11'((p / 4 + k / 3) * 6 + p % 4 + k % 3), 4'(k)});
        sel_q.push_back(1'b1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (wsram_rd_en_o || xsram_rd_en_o) begin
      check("rd_both", 32'(wsram_rd_en_o & xsram_rd_en_o), 0);
      check("rd_while_full", 32'(l0_full_i), 0);
      check("rd_busy", 32'(busy_o), 1);
      if (exp_q.size() == 0) begin
        check("extra_read", 1, 0);
      end else begin
        rd_t e;
        logic [10:0] a;
        e = exp_q.pop_front();
        a = xsram_rd_en_o ? xsram_addr_o : wsram_addr_o;
        check("rd_kind", 32'(xsram_rd_en_o), 32'(e.is_x));
        check("rd_addr", 32'(a), 32'(e.addr));
        check("rd_kij", 32'(kij_o), 32'(e.kij));
      end
      rd_log.push_back('{cyc - start_cyc, xsram_rd_en_o, xsram_rd_en_o ? xsram_addr_o : wsram_addr_o, kij_o});
    end
    if (l0_wr_en_o) begin
      if (sel_q.size() == 0) check("extra_write", 1, 0);
      else check("wr_sel", 32'(l0_sel_o), 32'(sel_q.pop_front()));
      wr_log.push_back('{cyc - start_cyc, l0_sel_o});
    end
    if (done_o) done_log.push_back(cyc - start_cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0: return xsram_rd_en_o;
      1: return wsram_rd_en_o;
      default: return done_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string nm);
    int n = 0;
    while (!sig(which) && n < 80) begin
      step();
      n++;
    end
    if (n >= 80) check(nm, 0, 1);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_wrd"}, 32'(wsram_rd_en_o), 0);
    check({nm, "_waddr"}, 32'(wsram_addr_o), 0);
    check({nm, "_xrd"}, 32'(xsram_rd_en_o), 0);
    check({nm, "_xaddr"}, 32'(xsram_addr_o), 0);
    check({nm, "_l0wr"}, 32'(l0_wr_en_o), 0);
    check({nm, "_l0sel"}, 32'(l0_sel_o), 0);
    check({nm, "_kij"}, 32'(kij_o), 0);
    check({nm, "_busy"}, 32'(busy_o), 0);
    check({nm, "_done"}, 32'(done_o), 0);
  endtask

  int x0[16] = '{0, 1, 2, 3, 6, 7, 8, 9, 12, 13, 14, 15, 18, 19, 20, 21};
  int x4[16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

  initial begin
    model_init();
    step(); step();
    check_idle("reset");
    reset = 1'b1;
    step();

    // Run 1: no back-pressure, no next_kij.
    start_i = 1'b1; start_cyc = cyc;
    step(); start_i = 1'b0;
    repeat (30) step();
    check("r1_reads", rd_log.size(), 24);
    for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
      check("r1_w_rel", rd_log[i].rel, i + 1);
      check("r1_w_addr", 32'(rd_log[i].addr), i);
    end
    for (int i = 0; i < 16 && i + 8 < rd_log.size(); i++) begin
      check("r1_x_rel", rd_log[i + 8].rel, i + 9);
      check("r1_x_addr", 32'(rd_log[i + 8].addr), x0[i]);
    end
    check("r1_writes", wr_log.size(), 24);
    if (wr_log.size() == 24) begin
      check("r1_wr_first", wr_log[0].rel, 2);
      check("r1_wr_w_last", wr_log[7].rel, 9);
      check("r1_wr_w_sel", 32'(wr_log[7].sel), 0);
      check("r1_wr_x_first_sel", 32'(wr_log[8].sel), 1);
      check("r1_wr_last", wr_log[23].rel, 25);
    end
    check("r1_wait_busy", 32'(busy_o), 1);
    check("r1_wait_kij", 32'(kij_o), 0);

    for (int j = 1; j <= 4; j++) begin
      next_kij_i = 1'b1;
      step(); next_kij_i = 1'b0;
      if (j == 4) check("r1_kij4", 32'(kij_o), 4);
      repeat (29) step();
    end
    check("r1_reads_k4", rd_log.size(), 120);
    for (int i = 0; i < 24 && 96 + i < rd_log.size(); i++) begin
      check("r1_k4_addr", 32'(rd_log[96 + i].addr), (i < 8) ? 32 + i : x4[i - 8]);
    end

    // Into kij 5 and reset mid-LOAD_X.
    next_kij_i = 1'b1;
    step(); next_kij_i = 1'b0;
    repeat (12) step();
    check("r1_in_loadx", 32'(xsram_rd_en_o), 1);
    reset = 1'b0;
    step();
    model_init();
    check_idle("midrst");
    step();
    reset = 1'b1;
    step();

    // Run 2: restart, stall 3 cycles after the 3rd weight read, then prompt next_kij.
    start_i = 1'b1; start_cyc = cyc;
    step(); start_i = 1'b0;
    step(); step(); step();
    l0_full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_rd", 32'(wsram_rd_en_o | xsram_rd_en_o), 0);
      check("stall_addr_hold", 32'(wsram_addr_o), 3);
      step();
    end
    l0_full_i = 1'b0;
`ifdef L0_LOAD_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt_o), 3);
`endif
    for (int k = 0; k < 9; k++) begin
      wait_sig(0, "timeout_x");
      next_kij_i = 1'b1;
      step(); next_kij_i = 1'b0;
      if (k < 8) wait_sig(1, "timeout_w");
      else wait_sig(2, "timeout_done");
    end
    step();
    check("r2_busy_after_done", 32'(busy_o), 0);
    check("r2_done_after", 32'(done_o), 0);
    step(); step();
    check("r2_total_writes", wr_log.size(), 216);
    check("r2_exp_left", exp_q.size(), 0);
    check("r2_done_pulses", done_log.size(), 1);
    if (rd_log.size() == 216) begin
      check("r2_restart_addr", 32'(rd_log[0].addr), 0);
      check("r2_restart_rel", rd_log[0].rel, 1);
      check("r2_resume_rel", rd_log[3].rel, 7);
      check("r2_resume_addr", 32'(rd_log[3].addr), 3);
      check("r2_k0_last_w", 32'(rd_log[7].addr), 7);
      check("r2_k0_first_x", 32'(rd_log[8].is_x), 1);
      check("r2_wait_gap", rd_log[24].rel - rd_log[23].rel, 2);
      check("r2_k1_addr", 32'(rd_log[24].addr), 8);
      check("r2_k1_kij", 32'(rd_log[24].kij), 1);
      if (done_log.size() == 1) check("r2_done_rel", done_log[0], rd_log[215].rel + 2);
    end else begin
      check("r2_reads", rd_log.size(), 216);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
